// File: rtl/net_tx_rr_arbiter.sv
// Packet-level round-robin arbiter merging N_PORTS AXI4-Stream requesters
// onto one TX stream; a grant is held from first beat through tlast.
module net_tx_rr_arbiter #(
  parameter  int N_PORTS    = 4,
  parameter  int DATA_WIDTH = 512,
  parameter  int CNT_WIDTH  = 32,
  localparam int KW         = DATA_WIDTH / 8,
  localparam int GW         = $clog2(N_PORTS)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  output logic [N_PORTS-1:0]            s_axis_tready,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS*KW-1:0]         s_axis_tkeep,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KW-1:0]                 m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [N_PORTS*CNT_WIDTH-1:0]  pkt_cnt
);

  typedef enum logic {ARB, FWD} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] idx;
  logic [GW-1:0] ptr_nxt;
  logic          found;
  logic          eop;

  // first valid port at or after rr_ptr, wrapping modulo N_PORTS
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = GW'((int'(rr_ptr) + k) % N_PORTS);
      if (!found && s_axis_tvalid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign busy = (state == FWD);

  always_comb begin
    s_axis_tready = '0;
    if (state == FWD)
      s_axis_tready[grant_id] = m_axis_tready;
  end

  assign m_axis_tvalid = busy && s_axis_tvalid[grant_id];
  assign m_axis_tdata  = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tkeep  = s_axis_tkeep[grant_id*KW +: KW];
  assign m_axis_tlast  = s_axis_tlast[grant_id];

  assign eop = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  assign ptr_nxt = (grant_id == GW'(N_PORTS - 1)) ? '0
                 : grant_id + GW'(1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ARB;
      rr_ptr   <= '0;
      grant_id <= '0;
      pkt_cnt  <= '0;
    end else begin
      unique case (state)
        ARB: begin
          if (found) begin
            grant_id <= win;
            state    <= FWD;
          end
        end
        FWD: begin
          if (eop) begin
            pkt_cnt[grant_id*CNT_WIDTH +: CNT_WIDTH] <=
              pkt_cnt[grant_id*CNT_WIDTH +: CNT_WIDTH]
              + CNT_WIDTH'(1);
            rr_ptr <= ptr_nxt;
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_rr_arbiter.sv
// Randomized bench for net_tx_rr_arbiter with a packet-level
// round-robin reference model and per-scenario tasks.
module tb_net_tx_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int CW = 32;
  localparam int NW = 2;
  localparam int GW = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b1;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic [N*CW-1:0] pkt_cnt;

  logic [N-1:0]    w_tready;
  logic            w_tvalid;
  logic [DW-1:0]   w_tdata;
  logic [KW-1:0]   w_tkeep;
  logic            w_tlast;
  logic [GW-1:0]   w_grant;
  logic            w_busy;
  logic [N*NW-1:0] w_cnt;

  always #5 aclk = ~aclk;

  net_tx_rr_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  // narrow-counter copy on the same stimulus exposes counter wrap
  net_tx_rr_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .CNT_WIDTH(NW)
  ) dut_w (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(w_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(w_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(w_tdata), .m_axis_tkeep(w_tkeep),
    .m_axis_tlast(w_tlast),
    .grant_id(w_grant), .busy(w_busy), .pkt_cnt(w_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t       src_q[N][$];
  beat_t       out_log[$];
  int          done_q[$];
  logic [31:0] mcnt[N];
  bit          m_fwd;
  int          m_gnt;
  int          m_ptr;
  bit          gate[N];
  bit          rand_gate;
  int          rdy_mode;
  int          beats_out[N];
  int          first_cyc[N];
  int          last_cyc[N];
  int          cyc;
  int          errors;
  int          checks;

  task automatic load(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = $urandom;
      b.k = KW'($urandom);
      b.l = (i == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_tvalid[i] = gate[i];
        s_axis_tdata[i*DW +: DW] = src_q[i][0].d;
        s_axis_tkeep[i*KW +: KW] = src_q[i][0].k;
        s_axis_tlast[i] = src_q[i][0].l;
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tkeep[i*KW +: KW] = '0;
        s_axis_tlast[i] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_fwd = 0;
    m_gnt = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = '0;
      src_q[i].delete();
      beats_out[i] = 0;
    end
  endtask

  function automatic bit pending();
    bit r;
    r = m_fwd;
    for (int i = 0; i < N; i++)
      if (src_q[i].size() > 0) r = 1;
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s m_tvalid got=%b exp=0", tag, m_axis_tvalid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got=%b exp=0", tag, busy);
    end
    checks++;
    if (grant_id !== '0) begin
      errors++;
      $display("FAIL %s grant_id got=%0d exp=0", tag, grant_id);
    end
    checks++;
    if (s_axis_tready !== '0) begin
      errors++;
      $display("FAIL %s s_tready got=%b exp=0", tag, s_axis_tready);
    end
    checks++;
    if (pkt_cnt !== '0 || w_cnt !== '0) begin
      errors++;
      $display("FAIL %s pkt_cnt got=%h/%h exp=0", tag, pkt_cnt, w_cnt);
    end
  endtask

  // one clock: compare against the model at negedge, then advance it
  task automatic cycle();
    logic [N-1:0]    e_rdy;
    logic            e_v;
    logic [N*CW-1:0] e_cnt;
    logic [N*NW-1:0] e_w;
    beat_t           b;
    bit              hit;
    int              p;
    @(negedge aclk);
    e_rdy = '0;
    e_v = 1'b0;
    if (m_fwd) begin
      e_v = s_axis_tvalid[m_gnt];
      e_rdy[m_gnt] = m_axis_tready;
    end
    for (int i = 0; i < N; i++) begin
      e_cnt[i*CW +: CW] = mcnt[i];
      e_w[i*NW +: NW] = mcnt[i][NW-1:0];
    end
    checks++;
    if (m_axis_tvalid !== e_v) begin
      errors++;
      $display("FAIL m_tvalid cyc=%0d got=%b exp=%b",
               cyc, m_axis_tvalid, e_v);
    end
    checks++;
    if (busy !== m_fwd) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_fwd);
    end
    checks++;
    if (grant_id !== GW'(m_gnt)) begin
      errors++;
      $display("FAIL grant_id cyc=%0d got=%0d exp=%0d",
               cyc, grant_id, m_gnt);
    end
    checks++;
    if (s_axis_tready !== e_rdy) begin
      errors++;
      $display("FAIL s_tready cyc=%0d got=%b exp=%b",
               cyc, s_axis_tready, e_rdy);
    end
    checks++;
    if (pkt_cnt !== e_cnt) begin
      errors++;
      $display("FAIL pkt_cnt cyc=%0d got=%h exp=%h", cyc, pkt_cnt, e_cnt);
    end
    checks++;
    if (w_cnt !== e_w) begin
      errors++;
      $display("FAIL pkt_cnt_wrap cyc=%0d got=%h exp=%h", cyc, w_cnt, e_w);
    end
    if (e_v) begin
      b = src_q[m_gnt][0];
      checks++;
      if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== b) begin
        errors++;
        $display("FAIL m_beat cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc,
                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, b.d, b.k, b.l);
      end
    end
    if (!m_fwd) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!hit && s_axis_tvalid[p]) begin
          hit = 1;
          m_fwd = 1;
          m_gnt = p;
        end
      end
    end else if (s_axis_tvalid[m_gnt] && m_axis_tready) begin
      b = src_q[m_gnt].pop_front();
      out_log.push_back(b);
      if (beats_out[m_gnt] == 0) first_cyc[m_gnt] = cyc;
      last_cyc[m_gnt] = cyc;
      beats_out[m_gnt]++;
      if (b.l) begin
        mcnt[m_gnt] = mcnt[m_gnt] + 32'd1;
        m_ptr = (m_gnt + 1) % N;
        m_fwd = 0;
        done_q.push_back(m_gnt);
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (rdy_mode == 1) m_axis_tready = ~m_axis_tready;
    else if (rdy_mode == 2) m_axis_tready = 1'($urandom);
    if (rand_gate)
      for (int i = 0; i < N; i++) gate[i] = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic run_idle(input string tag, input int budget,
                          output int n);
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout got=%0d cycles exp<%0d", tag, n, budget);
    end
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    checks++;
    if (done_q != exp) begin
      errors++;
      $display("FAIL %s order got=%p exp=%p", tag, done_q, exp);
    end
  endtask

  task automatic test_reset();
    m_axis_tready = 1'b1;
    rdy_mode = 0;
    rand_gate = 0;
    for (int i = 0; i < N; i++) gate[i] = 1;
    model_reset();
    drive();
    #1 aresetn = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_idle();
    repeat (10) cycle();
  endtask

  task automatic test_fairness();
    int n;
    done_q.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) load(p, 3);
    drive();
    run_idle("fair", 100, n);
    check_order("fair", '{0, 1, 2, 3, 0, 1, 2, 3});
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL fair_cycles got=%0d exp=32", n);
    end
    for (int p = 0; p < N; p++) begin
      checks++;
      if (pkt_cnt[p*CW +: CW] !== 32'd2) begin
        errors++;
        $display("FAIL fair_cnt%0d got=%0d exp=2", p, pkt_cnt[p*CW +: CW]);
      end
    end
  endtask

  task automatic test_no_interleave();
    int n;
    done_q.delete();
    for (int i = 0; i < N; i++) beats_out[i] = 0;
    load(1, 4);
    load(2, 2);
    gate[2] = 0;
    drive();
    n = 0;
    while (beats_out[1] < 1 && n < 20) begin
      cycle();
      n++;
    end
    gate[2] = 1;
    drive();
    run_idle("intlv", 50, n);
    check_order("intlv", '{1, 2});
    checks++;
    if (last_cyc[1] - first_cyc[1] != 3 || first_cyc[2] <= last_cyc[1])
    begin
      errors++;
      $display("FAIL intlv_span got=%0d..%0d p2=%0d exp=contiguous 4",
               first_cyc[1], last_cyc[1], first_cyc[2]);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp_b[$];
    int n;
    out_log.delete();
    load(3, 5);
    exp_b = src_q[3];
    rdy_mode = 1;
    drive();
    run_idle("bp", 60, n);
    rdy_mode = 0;
    m_axis_tready = 1'b1;
    drive();
    checks++;
    if (out_log != exp_b) begin
      errors++;
      $display("FAIL bp_data got=%0d beats exp=%0d beats in order",
               out_log.size(), exp_b.size());
    end
    checks++;
    if (pkt_cnt[3*CW +: CW] !== 32'd3) begin
      errors++;
      $display("FAIL bp_cnt3 got=%0d exp=3", pkt_cnt[3*CW +: CW]);
    end
  endtask

  task automatic test_wrap_skip();
    int n;
    done_q.delete();
    load(2, 2);
    drive();
    run_idle("wrap_a", 30, n);
    load(1, 1);
    drive();
    run_idle("wrap_b", 30, n);
    load(1, 1);
    load(2, 1);
    load(3, 1);
    drive();
    run_idle("wrap_c", 30, n);
    check_order("wrap", '{2, 1, 2, 3, 1});
  endtask

  task automatic test_random();
    int n;
    int p;
    rdy_mode = 2;
    rand_gate = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, N - 1);
        if (src_q[p].size() < 8) load(p, $urandom_range(1, 6));
        drive();
      end
      cycle();
    end
    rand_gate = 0;
    rdy_mode = 0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) gate[i] = 1;
    drive();
    run_idle("rand", 400, n);
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < N; i++) beats_out[i] = 0;
    load(2, 6);
    drive();
    n = 0;
    while (beats_out[2] < 1 && n < 20) begin
      cycle();
      n++;
    end
    aresetn = 1'b0;
    #1 check_reset_outputs("reset_mid");
    model_reset();
    drive();
    #2 aresetn = 1'b1;
    done_q.delete();
    load(3, 1);
    load(0, 1);
    drive();
    run_idle("rst_mid", 30, n);
    check_order("rst_mid", '{0, 3});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = '0;
    test_reset();
    test_idle();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_wrap_skip();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
